// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port between the ALU writeback
// (requester 0) and the load unit (requester 1), plus a pending-write scoreboard.
module reg_write_arbiter #(
   parameter int NREG    = 16,
   parameter bit RR_INIT = 1'b0,
   localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic            C,
   input  logic            rst,
   input  logic            stall,
   input  logic            req0_valid,
   input  logic [AW-1:0]   req0_addr,
   input  logic [1:0]      req0_half,
   input  logic [15:0]     req0_data,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [AW-1:0]   req1_addr,
   input  logic [1:0]      req1_half,
   input  logic [15:0]     req1_data,
   output logic            req1_ready,
   input  logic            rsv_valid,
   input  logic [AW-1:0]   rsv_addr,
   input  logic [AW-1:0]   chk_addr,
   output logic            chk_pending,
   output logic [NREG-1:0] wr_en,
   output logic [1:0]      wr_half,
   output logic [15:0]     wr_data,
   output logic            wr_src
);

   // state | meaning
   // PRI0  | requester 0 wins when both are valid
   // PRI1  | requester 1 wins when both are valid
   typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} ptr_t;

   ptr_t            ptr_q, ptr_d;
   logic            xfer;
   logic [AW-1:0]   win_addr;
   logic [NREG-1:0] win_dec, rsv_dec, chk_dec, pending;

   // Addresses with no matching register decode to all-zero, so an out-of-range
   // address neither enables a write nor touches the scoreboard.
   function automatic logic [NREG-1:0] dec(input logic [AW-1:0] a);
      logic [NREG-1:0] r;
      r = '0;
      for (int i = 0; i < NREG; i++)
         if (a == i[AW-1:0]) r[i] = 1'b1;
      return r;
   endfunction

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      ptr_d      = ptr_q;
      if (!stall) begin
         req0_ready = req0_valid && (!req1_valid || ptr_q == PRI0);
         req1_ready = req1_valid && (!req0_valid || ptr_q == PRI1);
      end
      if (req0_ready)      ptr_d = PRI1;
      else if (req1_ready) ptr_d = PRI0;
   end

   always_comb begin
      xfer        = req0_ready | req1_ready;
      win_addr    = req1_ready ? req1_addr : req0_addr;
      win_dec     = xfer ? dec(win_addr) : '0;
      rsv_dec     = rsv_valid ? dec(rsv_addr) : '0;
      chk_dec     = dec(chk_addr);
      chk_pending = |(pending & chk_dec);
   end

   always_ff @(posedge C) begin
      if (rst) begin
         ptr_q   <= RR_INIT ? PRI1 : PRI0;
         pending <= '0;
         wr_en   <= '0;
         wr_half <= 2'b00;
         wr_data <= 16'h0000;
         wr_src  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         // Set is applied after clear so a same-cycle reserve keeps the bit high.
         pending <= (pending & ~win_dec) | rsv_dec;
         wr_en   <= win_dec;
         if (xfer) begin
            wr_half <= req1_ready ? req1_half : req0_half;
            wr_data <= req1_ready ? req1_data : req0_data;
            wr_src  <= req1_ready;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: stimulus pushes expected bank writes into a
// queue, a negedge monitor pops and compares whenever wr_en is asserted.
module tb_reg_write_arbiter;

   logic        C = 1'b0;
   logic        rst, stall;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_addr, req1_addr, rsv_addr, chk_addr;
   logic [1:0]  req0_half, req1_half, wr_half;
   logic [15:0] req0_data, req1_data, wr_data, wr_en;
   logic        rsv_valid, chk_pending, wr_src;

   typedef struct {
      logic [15:0] en;
      logic [1:0]  half;
      logic [15:0] data;
      logic        src;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   npass = 0;
   int   ntot  = 0;
   int   cyc   = 0;
   bit   mon_on = 1'b0;

   reg_write_arbiter #(.NREG(16), .RR_INIT(1'b0)) dut (
      .C(C), .rst(rst), .stall(stall),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_half(req0_half),
      .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_half(req1_half),
      .req1_data(req1_data), .req1_ready(req1_ready),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .chk_addr(chk_addr), .chk_pending(chk_pending),
      .wr_en(wr_en), .wr_half(wr_half), .wr_data(wr_data), .wr_src(wr_src)
   );

   always #5 C = ~C;
   always @(posedge C) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(negedge C) begin
      if (mon_on && wr_en != 16'h0000) begin
         if (q.size() == 0) begin
            check("unexpected_wr_en", 32'(wr_en), 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("wr_en",   32'(wr_en),   32'(e.en));
            check("wr_half", 32'(wr_half), 32'(e.half));
            check("wr_data", 32'(wr_data), 32'(e.data));
            check("wr_src",  32'(wr_src),  32'(e.src));
            check("wr_cycle", 32'(cyc),    32'(e.cyc));
         end
      end
   end

   task automatic idle_in();
      stall = 0; rsv_valid = 0; rsv_addr = 0; chk_addr = 0;
      req0_valid = 0; req0_addr = 0; req0_half = 0; req0_data = 0;
      req1_valid = 0; req1_addr = 0; req1_half = 0; req1_data = 0;
   endtask

   // One cycle: check readies (and optionally chk_pending), record the expected write.
   task automatic step(input logic e0, input logic e1, input int echk);
      @(negedge C);
      check("req0_ready", 32'(req0_ready), 32'(e0));
      check("req1_ready", 32'(req1_ready), 32'(e1));
      if (echk >= 0) check("chk_pending", 32'(chk_pending), 32'(echk));
      if (!rst && !stall) begin
         if (e0) q.push_back('{16'd1 << req0_addr, req0_half, req0_data, 1'b0, cyc + 1});
         else if (e1) q.push_back('{16'd1 << req1_addr, req1_half, req1_data, 1'b1, cyc + 1});
      end
      @(posedge C); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_in(); rst = 1;
      @(posedge C); @(posedge C); #1;
      check("rst_wr_en",   32'(wr_en),   32'h0);
      check("rst_wr_half", 32'(wr_half), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_wr_src",  32'(wr_src),  32'h0);
      check("rst_pending", 32'(chk_pending), 32'h0);
      rst = 0; mon_on = 1;

      // single requester 0 write
      req0_valid = 1; req0_addr = 3; req0_half = 2'b00; req0_data = 16'hBEEF;
      step(1, 0, -1);
      idle_in();
      step(0, 0, -1);
      step(0, 0, -1);
      check("idle_wr_en",   32'(wr_en),   32'h0);
      check("hold_wr_data", 32'(wr_data), 32'hBEEF);

      // alternation from a fresh reset
      rst = 1; step(0, 0, -1); rst = 0;
      req0_valid = 1; req0_addr = 1; req0_half = 2'b00; req0_data = 16'h1111;
      req1_valid = 1; req1_addr = 2; req1_half = 2'b11; req1_data = 16'h2222;
      step(1, 0, -1);
      req0_addr = 4; req0_data = 16'h4444;
      step(0, 1, -1);
      req1_addr = 6; req1_data = 16'h6666;
      step(1, 0, -1);
      req0_addr = 8; req0_half = 2'b10; req0_data = 16'h8888;
      step(0, 1, -1);

      // stall holds the pointer (now on requester 0)
      req1_addr = 10; req1_data = 16'hAAAA;
      stall = 1;
      step(0, 0, -1);
      check("stall_wr_en", 32'(wr_en), 32'h0);
      step(0, 0, -1);
      stall = 0;
      step(1, 0, -1);
      idle_in();
      step(0, 0, -1);

      // reserve then clear through a requester 1 write
      rsv_valid = 1; rsv_addr = 5; chk_addr = 5;
      step(0, 0, 0);
      rsv_valid = 0;
      step(0, 0, 1);
      req1_valid = 1; req1_addr = 5; req1_half = 2'b01; req1_data = 16'h00AA;
      step(0, 1, 1);
      req1_valid = 0;
      step(0, 0, 0);

      // reserve and write to the same register in one cycle: set wins
      rsv_valid = 1; rsv_addr = 7; chk_addr = 7;
      step(0, 0, 0);
      req0_valid = 1; req0_addr = 7; req0_half = 2'b00; req0_data = 16'h7777;
      step(1, 0, 1);
      idle_in(); chk_addr = 7;
      step(0, 0, 1);

      // write to a non-pending register leaves it clear
      chk_addr = 3;
      req1_valid = 1; req1_addr = 3; req1_half = 2'b10; req1_data = 16'h0033;
      step(0, 1, 0);
      req1_valid = 0;
      step(0, 0, 0);

      // reset during a grant drops the write and restores pointer and scoreboard
      rsv_valid = 1; rsv_addr = 5;
      step(0, 0, -1);
      rsv_valid = 0;
      rst = 1;
      req0_valid = 1; req0_addr = 9; req0_data = 16'h1234;
      step(1, 0, -1);
      check("post_rst_wr_en", 32'(wr_en), 32'h0);
      rst = 0; idle_in(); chk_addr = 7;
      step(0, 0, 0);
      chk_addr = 5;
      step(0, 0, 0);
      req0_valid = 1; req0_addr = 12; req0_half = 2'b11; req0_data = 16'hC0DE;
      req1_valid = 1; req1_addr = 13; req1_half = 2'b00; req1_data = 16'hD00D;
      step(1, 0, -1);
      idle_in();
      step(0, 0, -1);
      step(0, 0, -1);

      check("queue_drained", 32'(q.size()), 32'h0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the single write port of a bank of NREG 16-bit half-addressable registers between two requesters: 0 = ALU writeback, 1 = load unit. Each requester uses a valid/ready handshake. The block arbitrates round-robin and registers the winning write onto the bank's per-register enable, half-select and data lines. It also keeps a pending-write scoreboard so issue logic can detect read-after-write hazards.

Parameters:
NREG, 16, number of registers in the bank (power of 2, 2..16); address width AW = log2(NREG).
RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
C  in  1  clock; all state updates on posedge C
rst  in  1  synchronous reset, active-high
stall  in  1  1 = suppress all grants this cycle
req0_valid  in  1  requester 0 has a write
req0_addr  in  AW  requester 0 target register
req0_half  in  2  requester 0 half code (00 full, 01 low byte from D[7:0], 10 high byte from D[7:0], 11 high byte from D[15:8])
req0_data  in  16  requester 0 write data
req0_ready  out  1  requester 0 granted this cycle (combinational)
req1_valid, req1_addr, req1_half, req1_data, req1_ready  same as requester 0, for requester 1
rsv_valid  in  1  reserve a register as pending
rsv_addr  in  AW  register to reserve
chk_addr  in  AW  scoreboard query address
chk_pending  out  1  pending[chk_addr] (combinational)
wr_en  out  NREG  one-hot write enable to the bank (registered)
wr_half  out  2  half code to the bank (registered)
wr_data  out  16  data to the bank (registered)
wr_src  out  1  requester that owns the current wr_en (registered)

Behaviour:
- Reset (rst=1 at posedge): wr_en=0, wr_half=00, wr_data=0, wr_src=0, priority pointer=RR_INIT, pending[]=all 0. rst overrides every other input.
- Handshake: a transfer occurs in a cycle where reqN_valid=1 and reqN_ready=1.
  - ready depends only on valid, stall and the pointer; it never depends on wr_*.
  - A requester holds valid/addr/half/data stable until it is granted.
- Grant (combinational) when stall=0:
  - Only one valid: grant it.
  - Both valid: grant the requester the pointer names.
  - Neither valid: no grant.
  - At most one ready is high per cycle.
- stall=1: req0_ready=req1_ready=0. At the next edge wr_en=0. The pointer holds.
- Pointer: after a transfer by requester i, the pointer becomes 1-i. With no transfer it holds.
- Latency: a transfer in cycle N drives, in cycle N+1:
  - wr_en = one-hot(addr)
  - wr_half, wr_data and wr_src from the winner
  The bank captures at the end of N+1. With no transfer, wr_en=0 in N+1 and wr_half/wr_data/wr_src hold their previous values.
- Throughput: one write per cycle, back-to-back. Both requesters valid every cycle alternate 0,1,0,1 (for RR_INIT=0).
- Same address from both requesters in one cycle: only the winner is written. The loser is written in a later cycle, so last-writer order follows grant order.
- Scoreboard:
  - rsv_valid=1 sets pending[rsv_addr] at the edge.
  - A transfer to addr A clears pending[A] at the same edge the write is registered, i.e. visible in cycle N+1.
  - A reserve and a clear for the same address in one cycle: the set wins and the bit stays 1.
  - Reserving an already-pending register leaves it at 1; there is no counting.
  - Writes to non-pending registers are legal and leave the bit unchanged at 0.
- Address at or above NREG (only possible when NREG is not a power of 2) is a protocol error: no enable asserted, pending unchanged.
- Reset asserted while a write is in flight drops the write: wr_en=0 in the cycle after reset.

Test Plan:
1. Reset, then only req0 valid with addr=3, half=00, data=16'hBEEF -> req0_ready=1 same cycle. Next cycle wr_en=16'h0008, wr_half=00, wr_data=BEEF, wr_src=0. The cycle after, wr_en=0.
2. Both requesters valid continuously for 4 cycles, RR_INIT=0 -> grants in order 0,1,0,1. wr_en is nonzero every cycle from the second onward. wr_src sequence 0,1,0,1.
3. Both valid, stall=1 for 2 cycles then 0 -> no ready and wr_en=0 during stall. First grant after stall goes to the requester the pointer held.
4. rsv_valid for addr 5 -> chk_addr=5 gives chk_pending=1 next cycle. req1 writes addr 5 with half=01, data=16'h00AA -> chk_pending=0 one cycle after the transfer. wr_half=01.
5. Same cycle: rsv_addr=7 and a granted write to addr 7 with pending[7]=1 -> pending[7] remains 1.
6. Grant in cycle N with rst=1 in cycle N -> wr_en=0 in N+1, pointer=RR_INIT, all pending bits 0.
